operand_accum_datapath: RTL

OPERAND_ACCUM_DATAPATH -- requirements
Module: operand_accum_datapath

---
 rtl/operand_accum_datapath_pkg.sv | 15 +
 rtl/operand_accum_datapath_if.sv | 26 ++
 rtl/operand_accum_datapath_operand_reg.sv | 20 ++
 rtl/operand_accum_datapath.sv | 94 +++++++++
 4 files changed

// File: rtl/operand_accum_datapath_pkg.sv
// rtl/operand_accum_datapath_pkg.sv - shared state encoding and result-width helper
package operand_accum_datapath_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  // One extra bit beyond the worst-case magnitude gives room for the sign.
  function automatic int result_width(input int width, input int nreg);
    return width + $clog2(nreg + 1) + 1;
  endfunction

endpackage

// File: rtl/operand_accum_datapath_if.sv
// rtl/operand_accum_datapath_if.sv - operand/command and result bundle
interface operand_accum_datapath_if #(
  parameter int WIDTH = 4,
  parameter int NREG  = 3,
  parameter int RW    = operand_accum_datapath_pkg::result_width(WIDTH, NREG)
) ();

  logic [WIDTH-1:0] d_in;
  logic [NREG-1:0]  capture;
  logic             start;
  logic [NREG:0]    sub_mask;
  logic             busy;
  logic             result_valid;
  logic [RW-1:0]    result;

  modport master (
    output d_in, capture, start, sub_mask,
    input  busy, result_valid, result
  );

  modport slave (
    input  d_in, capture, start, sub_mask,
    output busy, result_valid, result
  );

endinterface

// File: rtl/operand_accum_datapath_operand_reg.sv
// rtl/operand_accum_datapath_operand_reg.sv - load-enabled operand register
module operand_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/operand_accum_datapath.sv
// rtl/operand_accum_datapath.sv - serial signed add/subtract of captured operands plus live d_in
module operand_accum_datapath
  import operand_accum_datapath_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREG  = 3
) (
  input logic                       clock,
  input logic                       rst,
  operand_accum_datapath_if.slave   bus
);

  localparam int RW = result_width(WIDTH, NREG);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NREG - 1);

  state_t                      state;
  logic signed [RW-1:0]        acc;
  logic [IW-1:0]               idx;
  logic [NREG-1:0]             snap_sub;
  logic [RW-1:0]               result_q;
  logic                        result_valid_q;
  logic [NREG-1:0][WIDTH-1:0]  r_q;
  logic [WIDTH-1:0]            cur_op;
  logic                        cur_sub;
  logic signed [RW-1:0]        op_ext;
  logic signed [RW-1:0]        d_ext;

  // Operand registers only accept captures while the datapath is idle.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    operand_reg #(.WIDTH(WIDTH)) u_operand_reg (
      .clock (clock),
      .rst   (rst),
      .load  ((state == IDLE) && bus.capture[i]),
      .d     (bus.d_in),
      .q     (r_q[i])
    );
  end

  always_comb begin
    cur_op  = '0;
    cur_sub = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (idx == IW'(i)) begin
        cur_op  = r_q[i];
        cur_sub = snap_sub[i];
      end
    end
  end

  assign op_ext = {{(RW-WIDTH){1'b0}}, cur_op};
  assign d_ext  = {{(RW-WIDTH){1'b0}}, bus.d_in};

  always_ff @(posedge clock) begin
    if (rst) begin
      state          <= IDLE;
      acc            <= '0;
      idx            <= '0;
      snap_sub       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc      <= bus.sub_mask[NREG] ? -d_ext : d_ext;
            snap_sub <= bus.sub_mask[NREG-1:0];
            idx      <= '0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          acc <= cur_sub ? (acc - op_ext) : (acc + op_ext);
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state <= DONE;
          end
        end
        DONE: begin
          result_q       <= acc;
          result_valid_q <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = (state != IDLE);
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;

endmodule
